shift_normalizer16: RTL and testbench

//  Multi-cycle left-normalizer that sits upstream of the 16-bit barrel shifter.

---
 rtl/shift_normalizer16_if.sv | 30 +++
 rtl/shift_normalizer16.sv | 132 +++++++++++++
 tb/tb_shift_normalizer16.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/shift_normalizer16_if.sv
// Bundle between the left-normalizer, its upstream producer/downstream consumer,
// and the external barrel shifter it drives.
interface shift_normalizer16_if #(
  parameter int WIDTH = 16,
  parameter int CW    = $clog2(WIDTH)
);
  // Handshakes: a word moves on a rising edge where valid && ready are both high.
  // A source holds valid and its data stable until that edge; ready may change freely.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] sh_a;
  logic [CW-1:0]    sh_n;
  logic [WIDTH-1:0] sh_result;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] norm_out;
  logic [CW-1:0]    shift_cnt;
  logic             zero;

  modport slave (
    input  in_valid, data_in, sh_result, out_ready,
    output in_ready, sh_a, sh_n, out_valid, norm_out, shift_cnt, zero
  );

  modport master (
    output in_valid, data_in, sh_result, out_ready,
    input  in_ready, sh_a, sh_n, out_valid, norm_out, shift_cnt, zero
  );
endinterface

// File: rtl/shift_normalizer16.sv
// Multi-cycle left-normalizer: scans leading zeros one nibble per cycle (MSB first),
// drives an external barrel shifter, and returns the normalized word over valid/ready.
module shift_normalizer16 #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  shift_normalizer16_if.slave  bus,
  output logic [1:0]           dbg_state
);
  localparam int CW  = $clog2(WIDTH);
  localparam int NIB = WIDTH / 4;
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [CW-1:0]    sh_n_q, sh_n_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] norm_q, norm_d;
  logic [CW-1:0]    shift_cnt_q, shift_cnt_d;
  logic             zero_q, zero_d;

  logic [CW-1:0]    nib_base;
  logic [WIDTH-1:0] scan_word;
  logic [3:0]       nib;
  logic [CW-1:0]    lz_count;

  function automatic logic [1:0] lz4(input logic [3:0] n);
    casez (n)
      4'b1???: lz4 = 2'd0;
      4'b01??: lz4 = 2'd1;
      4'b001?: lz4 = 2'd2;
      default: lz4 = 2'd3;
    endcase
  endfunction

  // Shifting the held word left by 4k brings nibble k to the top, avoiding a variable part-select.
  assign nib_base  = {k_q, 2'b00};
  assign scan_word = sh_a_q << nib_base;
  assign nib       = scan_word[WIDTH-1 -: 4];
  assign lz_count  = nib_base + CW'(lz4(nib));

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    sh_a_d      = sh_a_q;
    sh_n_d      = sh_n_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    norm_d      = norm_q;
    shift_cnt_d = shift_cnt_q;
    zero_d      = zero_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sh_a_d     = bus.data_in;
          k_d        = '0;
          in_ready_d = 1'b0;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        if (nib != 4'd0) begin
          sh_n_d  = lz_count;
          state_d = SHIFT;
        end else if (k_q == K_LAST) begin
          // All-zero word: no shift is meaningful, so the shifter inputs are left untouched.
          zero_d      = 1'b1;
          shift_cnt_d = '0;
          norm_d      = '0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      SHIFT: begin
        norm_d      = bus.sh_result;
        shift_cnt_d = sh_n_q;
        zero_d      = 1'b0;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      sh_a_q      <= '0;
      sh_n_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      norm_q      <= '0;
      shift_cnt_q <= '0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      sh_a_q      <= sh_a_d;
      sh_n_q      <= sh_n_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      norm_q      <= norm_d;
      shift_cnt_q <= shift_cnt_d;
      zero_q      <= zero_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.sh_a      = sh_a_q;
  assign bus.sh_n      = sh_n_q;
  assign bus.out_valid = out_valid_q;
  assign bus.norm_out  = norm_q;
  assign bus.shift_cnt = shift_cnt_q;
  assign bus.zero      = zero_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_shift_normalizer16.sv
// Directed bench for shift_normalizer16 with a behavioural barrel shifter on the sh_* bus.
module tb_shift_normalizer16;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;
  int         checks = 0;
  int         errors = 0;
  logic [20:0] exp_q[$];

  always #5 clk = ~clk;

  shift_normalizer16_if bus ();

  assign bus.sh_result = bus.sh_a << bus.sh_n;

  shift_normalizer16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Sends one word, waits for the result, checks latency and fields, then optionally stalls
  // the consumer for 'hold' cycles while offering another word that must be ignored.
  task automatic run_vec(input logic [15:0] d, input logic [3:0] exp_cnt,
                         input logic [15:0] exp_norm, input logic exp_zero,
                         input int exp_lat, input int hold);
    logic [20:0] e;
    int lat;
    exp_q.push_back({exp_zero, exp_cnt, exp_norm});
    @(negedge clk);
    check_eq("in_ready_idle", bus.in_ready, 1);
    bus.data_in  = d;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.data_in  = 16'hDEAD;
    check_eq("in_ready_after_accept", bus.in_ready, 0);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq("latency", lat, exp_lat);
    e = exp_q.pop_front();
    check_eq("zero", bus.zero, e[20]);
    check_eq("shift_cnt", bus.shift_cnt, e[19:16]);
    check_eq("norm_out", bus.norm_out, e[15:0]);
    check_eq("in_ready_busy", bus.in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.data_in  = 16'h0001;
      @(posedge clk);
      #1;
      check_eq("hold_valid", bus.out_valid, 1);
      check_eq("hold_norm", bus.norm_out, e[15:0]);
      check_eq("hold_cnt", bus.shift_cnt, e[19:16]);
      check_eq("hold_in_ready", bus.in_ready, 0);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check_eq("out_valid_drop", bus.out_valid, 0);
    check_eq("in_ready_back", bus.in_ready, 1);
    check_eq("state_idle", dbg_state, 0);
    if (hold > 0) begin
      repeat (3) begin
        @(posedge clk);
        #1;
        check_eq("ignored_word_idle", dbg_state, 0);
        check_eq("ignored_word_no_out", bus.out_valid, 0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.data_in   = 16'h0000;
    bus.out_ready = 1'b0;
    #12;
    check_eq("rst_in_ready", bus.in_ready, 1);
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_norm", bus.norm_out, 0);
    check_eq("rst_cnt", bus.shift_cnt, 0);
    check_eq("rst_zero", bus.zero, 0);
    check_eq("rst_sh_a", bus.sh_a, 0);
    check_eq("rst_sh_n", bus.sh_n, 0);
    check_eq("rst_state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_vec(16'h0001, 4'd15, 16'h8000, 1'b0, 5, 0);
    run_vec(16'h5555, 4'd1,  16'hAAAA, 1'b0, 2, 0);
    run_vec(16'hB7BB, 4'd0,  16'hB7BB, 1'b0, 2, 0);
    run_vec(16'd1038, 4'd5,  16'h81C0, 1'b0, 3, 0);
    run_vec(16'd21,   4'd11, 16'hA800, 1'b0, 4, 0);
    run_vec(16'h0000, 4'd0,  16'h0000, 1'b1, 4, 0);
    check_eq("zero_sh_n_untouched", bus.sh_n, 11);
    check_eq("zero_sh_a", bus.sh_a, 0);
    run_vec(16'h5555, 4'd1,  16'hAAAA, 1'b0, 2, 3);

    // Reset mid-scan of 0x0001.
    @(negedge clk);
    bus.data_in  = 16'h0001;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2;
    check_eq("pre_rst_scan", dbg_state, 1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_state", dbg_state, 0);
    check_eq("mid_rst_in_ready", bus.in_ready, 1);
    check_eq("mid_rst_out_valid", bus.out_valid, 0);
    check_eq("mid_rst_norm", bus.norm_out, 0);
    check_eq("mid_rst_cnt", bus.shift_cnt, 0);
    check_eq("mid_rst_sh_a", bus.sh_a, 0);
    check_eq("mid_rst_sh_n", bus.sh_n, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(16'h0F00, 4'd4, 16'hF000, 1'b0, 3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
